// File: rtl/password_check_fsm_pkg.sv
// Shared door-lock definitions: keypad codes, controller state encoding and
// default delays that the motor sequencer also uses.
package door_lock_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        S_ENTRY   = 2'd0,
        S_OPEN    = 2'd1,
        S_RELEASE = 2'd2,
        S_LOCK    = 2'd3
    } state_t;

    localparam int unsigned DEF_LOCKOUT_DELAY = 240_000_000;
    localparam int unsigned DEF_ENTRY_TIMEOUT = 120_000_000;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/password_check_fsm_if.sv
// Keypad, sequencer and status signals of the password controller.
interface password_check_fsm_if;

    logic       KEY_VALID;
    logic [3:0] KEY_CODE;
    logic       SEQ_DONE;
    logic       PW_OK;
    logic       FAIL_PULSE;
    logic       LOCKED;
    logic [2:0] DIGIT_CNT;
    logic [1:0] TRY_CNT;

    modport master (
        output KEY_VALID, KEY_CODE, SEQ_DONE,
        input  PW_OK, FAIL_PULSE, LOCKED, DIGIT_CNT, TRY_CNT
    );

    modport slave (
        input  KEY_VALID, KEY_CODE, SEQ_DONE,
        output PW_OK, FAIL_PULSE, LOCKED, DIGIT_CNT, TRY_CNT
    );

endinterface

// File: rtl/password_check_fsm_key_entry_buffer.sv
// Digit shift register with a saturating count and a sticky overflow flag;
// the newest digit lands in the least significant nibble.
module key_entry_buffer #(
    parameter int PW_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                clear,
    input  logic [3:0]          digit,
    output logic [4*PW_LEN-1:0] buffer,
    output logic [2:0]          count,
    output logic                overflow
);

    logic [4*PW_LEN-1:0] buffer_q, buffer_d, shifted;
    logic [2:0]          count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                full;

    assign full = (count_q == 3'(PW_LEN));

    genvar gi;
    generate
        for (gi = 0; gi < PW_LEN; gi++) begin : g_shift
            if (gi == 0) begin : g_lsd
                assign shifted[3:0] = digit;
            end else begin : g_upper
                assign shifted[gi*4 +: 4] = buffer_q[(gi-1)*4 +: 4];
            end
        end
    endgenerate

    always_comb begin
        buffer_d   = buffer_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            buffer_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (push) begin
            // A full buffer keeps its contents; the extra digit only poisons the entry.
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                buffer_d = shifted;
                count_d  = count_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign buffer   = buffer_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/password_check_fsm.sv
// Door-lock password controller: collects keypad digits, checks them against
// a fixed code, hands unlock to the motor sequencer and enforces lockout.
module password_check_fsm
    import door_lock_pkg::*;
#(
    parameter int                  PW_LEN        = 4,
    parameter logic [4*PW_LEN-1:0] PASSWORD      = 16'h1234,
    parameter int                  MAX_TRIES     = 3,
    parameter int unsigned         LOCKOUT_DELAY = DEF_LOCKOUT_DELAY,
    parameter int unsigned         ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    password_check_fsm_if.slave   bus
);

    state_t              state_q, state_d;
    logic [1:0]          try_cnt_q, try_cnt_d, try_inc;
    logic [31:0]         delay_q, delay_d;
    logic                pw_ok_q, pw_ok_d;
    logic                fail_pulse_q, fail_pulse_d;
    logic                locked_q, locked_d;
    logic                buf_push, buf_clear;
    logic [4*PW_LEN-1:0] buf_value;
    logic [2:0]          digit_cnt;
    logic                overflow;
    logic                code_match;

    key_entry_buffer #(.PW_LEN(PW_LEN)) u_entry (
        .clk      (CLK),
        .rst_n    (RESET),
        .push     (buf_push),
        .clear    (buf_clear),
        .digit    (bus.KEY_CODE),
        .buffer   (buf_value),
        .count    (digit_cnt),
        .overflow (overflow)
    );

    assign try_inc    = try_cnt_q + 2'd1;
    assign code_match = (digit_cnt == 3'(PW_LEN)) && !overflow && (buf_value == PASSWORD);

    always_comb begin
        state_d      = state_q;
        try_cnt_d    = try_cnt_q;
        delay_d      = delay_q;
        fail_pulse_d = 1'b0;
        buf_push     = 1'b0;
        buf_clear    = 1'b0;
        case (state_q)
            S_ENTRY: begin
                if (bus.KEY_VALID) begin
                    // A key always wins over a coinciding timeout and restarts the idle count.
                    delay_d = '0;
                    if (is_digit(bus.KEY_CODE)) begin
                        buf_push = 1'b1;
                    end else if (bus.KEY_CODE == KEY_CLEAR) begin
                        buf_clear = 1'b1;
                    end else if (bus.KEY_CODE == KEY_ENTER && digit_cnt != 3'd0) begin
                        buf_clear = 1'b1;
                        if (code_match) begin
                            try_cnt_d = '0;
                            state_d   = S_OPEN;
                        end else begin
                            fail_pulse_d = 1'b1;
                            try_cnt_d    = try_inc;
                            if (try_inc == 2'(MAX_TRIES)) begin
                                state_d = S_LOCK;
                            end
                        end
                    end
                end else if (digit_cnt != 3'd0) begin
                    if (delay_q == 32'(ENTRY_TIMEOUT - 1)) begin
                        buf_clear = 1'b1;
                        delay_d   = '0;
                    end else begin
                        delay_d = delay_q + 32'd1;
                    end
                end else begin
                    delay_d = '0;
                end
            end
            S_OPEN: begin
                if (bus.SEQ_DONE) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.SEQ_DONE) state_d = S_ENTRY;
                delay_d = '0;
            end
            S_LOCK: begin
                if (delay_q == 32'(LOCKOUT_DELAY - 1)) begin
                    state_d   = S_ENTRY;
                    try_cnt_d = '0;
                    delay_d   = '0;
                end else begin
                    delay_d = delay_q + 32'd1;
                end
            end
            default: state_d = S_ENTRY;
        endcase
        pw_ok_d  = (state_d == S_OPEN);
        locked_d = (state_d == S_LOCK);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_ENTRY;
            try_cnt_q    <= '0;
            delay_q      <= '0;
            pw_ok_q      <= 1'b0;
            fail_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            try_cnt_q    <= try_cnt_d;
            delay_q      <= delay_d;
            pw_ok_q      <= pw_ok_d;
            fail_pulse_q <= fail_pulse_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.PW_OK      = pw_ok_q;
    assign bus.FAIL_PULSE = fail_pulse_q;
    assign bus.LOCKED     = locked_q;
    assign bus.DIGIT_CNT  = digit_cnt;
    assign bus.TRY_CNT    = try_cnt_q;

endmodule
